// File: rtl/commit_trace_pkg.sv
// Shared widths, entry layout and pointer helper for the commit trace buffer.
// The TRACE_MEM_WATCH_EN build of the top level appends one watched memory word to each entry.
package commit_trace_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_PC_W     = 32;
   localparam int unsigned INST_W       = 32;
   localparam int unsigned DEF_RADDR_W  = 5;
   localparam int unsigned DEF_NUM_TAPS = 4;
   localparam int unsigned DEF_DEPTH    = 16;
   localparam int unsigned DEF_CNT_W    = 16;
   localparam int unsigned DEF_PTR_W    = $clog2(DEF_DEPTH) + 1;

   typedef struct packed {
      logic [DEF_PC_W-1:0]                 pc;
      logic [INST_W-1:0]                   inst;
      logic [DEF_NUM_TAPS*DEF_DATA_W-1:0]  taps;
   } trace_entry_t;

   // Pointer width carries one extra wrap bit to tell full from empty.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic DEPTH-entry FIFO with wrap-bit pointers, drop-or-evict on full and a
// saturating drop counter. Head data reads combinationally and is zero when empty.
module trace_fifo
   import commit_trace_pkg::*;
#(
   parameter int unsigned ENTRY_W = 192,
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear_i,
   input  logic                          push_i,
   input  logic                          pop_i,
   input  logic                          overwrite_i,
   input  logic [ENTRY_W-1:0]            push_data_i,
   output logic                          out_valid_o,
   output logic [ENTRY_W-1:0]            out_data_o,
   output logic [ptr_width(DEPTH)-1:0]   count_o,
   output logic [CNT_W-1:0]              drop_cnt_o
);

   localparam int unsigned PTR_W = ptr_width(DEPTH);
   localparam int unsigned IDX_W = PTR_W - 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               empty, full, do_pop, wr_en;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                  (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
   assign do_pop = pop_i && !empty;

   // Clear wins; a full push either drops or evicts the head, and counts as lost either way.
   always_comb begin
      wr_en    = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      drop_d   = drop_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         drop_d   = '0;
      end else begin
         if (push_i) begin
            if (!full || do_pop) begin
               wr_en = 1'b1;
            end else begin
               if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
               if (overwrite_i) begin
                  wr_en    = 1'b1;
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
               end
            end
         end
         if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
   end

   assign out_valid_o = !empty;
   assign out_data_o  = empty ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
   assign count_o     = wr_ptr_q - rd_ptr_q;
   assign drop_cnt_o  = drop_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: shadows NUM_TAPS selectable registers and records {pc, inst, taps}
// per qualified commit. Define TRACE_MEM_WATCH_EN to add a watched memory word to each entry.
module commit_trace_buffer
   import commit_trace_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned PC_W     = DEF_PC_W,
   parameter int unsigned RADDR_W  = DEF_RADDR_W,
   parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         clear,
   input  logic                         mode_filter,
   input  logic                         overwrite,
   input  logic [NUM_TAPS*RADDR_W-1:0]  tap_sel,
   input  logic                         commit_valid,
   input  logic [PC_W-1:0]              commit_pc,
   input  logic [INST_W-1:0]            commit_inst,
   input  logic                         rf_wr_en,
   input  logic [RADDR_W-1:0]           rf_wr_addr,
   input  logic [DATA_W-1:0]            rf_wr_data,
`ifdef TRACE_MEM_WATCH_EN
   input  logic                         mem_wr_en,
   input  logic [31:0]                  mem_addr,
   input  logic [DATA_W-1:0]            mem_wr_data,
   input  logic [31:0]                  watch_addr,
   output logic [DATA_W-1:0]            watch_data,
   output logic [DATA_W-1:0]            out_watch,
`endif
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PC_W-1:0]              out_pc,
   output logic [INST_W-1:0]            out_inst,
   output logic [NUM_TAPS*DATA_W-1:0]   out_taps,
   output logic [NUM_TAPS*DATA_W-1:0]   tap_live,
   output logic [$clog2(DEPTH):0]       count,
   output logic [CNT_W-1:0]             drop_cnt
);

`ifdef TRACE_MEM_WATCH_EN
   localparam int unsigned ENTRY_W = PC_W + INST_W + NUM_TAPS*DATA_W + DATA_W;
`else
   localparam int unsigned ENTRY_W = PC_W + INST_W + NUM_TAPS*DATA_W;
`endif

   logic [NUM_TAPS*DATA_W-1:0] tap_q, tap_d;
   logic                       hit, push;
   logic [ENTRY_W-1:0]         push_data, head_data;
`ifdef TRACE_MEM_WATCH_EN
   logic [DATA_W-1:0]          watch_q, watch_d;
`endif

   // Next shadow state doubles as the bypassed capture value (post-commit state).
   always_comb begin
      tap_d = tap_q;
      hit   = 1'b0;
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
         if (rf_wr_en && (rf_wr_addr != '0) &&
             (rf_wr_addr == tap_sel[i*RADDR_W +: RADDR_W])) begin
            tap_d[i*DATA_W +: DATA_W] = rf_wr_data;
            hit = 1'b1;
         end
      end
`ifdef TRACE_MEM_WATCH_EN
      watch_d = watch_q;
      if (mem_wr_en && (mem_addr == watch_addr)) begin
         watch_d = mem_wr_data;
         hit     = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tap_q <= '0;
      end else begin
         tap_q <= tap_d;
      end
   end

`ifdef TRACE_MEM_WATCH_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         watch_q <= '0;
      end else begin
         watch_q <= watch_d;
      end
   end

   assign watch_data = watch_q;
   assign push_data  = {commit_pc, commit_inst, tap_d, watch_d};
`else
   assign push_data  = {commit_pc, commit_inst, tap_d};
`endif

   assign push     = enable && commit_valid && (!mode_filter || hit);
   assign tap_live = tap_q;

   trace_fifo #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (clear),
      .push_i      (push),
      .pop_i       (out_ready),
      .overwrite_i (overwrite),
      .push_data_i (push_data),
      .out_valid_o (out_valid),
      .out_data_o  (head_data),
      .count_o     (count),
      .drop_cnt_o  (drop_cnt)
   );

`ifdef TRACE_MEM_WATCH_EN
   assign {out_pc, out_inst, out_taps, out_watch} = head_data;
`else
   assign {out_pc, out_inst, out_taps} = head_data;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: table of single-edge vectors plus
// hand sequences for fill/drop/evict, saturation, async reset and clear.
module tb_commit_trace_buffer;

   localparam int unsigned DW = 32;
   localparam int unsigned PW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned NT = 4;
   localparam int unsigned DP = 16;
   localparam int unsigned CW = 3;
   localparam logic [31:0] INST_X = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst, enable, clear, mode_filter, overwrite;
   logic [NT*RW-1:0]  tap_sel;
   logic              commit_valid, rf_wr_en, out_ready, out_valid;
   logic [PW-1:0]     commit_pc, out_pc;
   logic [31:0]       commit_inst, out_inst;
   logic [RW-1:0]     rf_wr_addr;
   logic [DW-1:0]     rf_wr_data;
   logic [NT*DW-1:0]  out_taps, tap_live;
   logic [4:0]        count;
   logic [CW-1:0]     drop_cnt;
`ifdef TRACE_MEM_WATCH_EN
   logic              mem_wr_en = 1'b0;
   logic [31:0]       mem_addr = '0, watch_addr = 32'h100;
   logic [DW-1:0]     mem_wr_data = '0, watch_data, out_watch;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   commit_trace_buffer #(
      .DATA_W(DW), .PC_W(PW), .RADDR_W(RW), .NUM_TAPS(NT), .DEPTH(DP), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .mode_filter(mode_filter), .overwrite(overwrite), .tap_sel(tap_sel),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
`ifdef TRACE_MEM_WATCH_EN
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .watch_addr(watch_addr), .watch_data(watch_data), .out_watch(out_watch),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_inst(out_inst), .out_taps(out_taps), .tap_live(tap_live),
      .count(count), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic         cv;
      logic [31:0]  pc;
      logic         we;
      logic [4:0]   wa;
      logic [31:0]  wd;
      logic         filt;
      logic         en;
      logic         rdy;
      logic [4:0]   e_cnt;
      logic         e_val;
      logic [31:0]  e_pc;
      logic [127:0] e_taps;
      logic [127:0] e_live;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      commit_valid = 1'b0;
      commit_pc    = '0;
      commit_inst  = '0;
      rf_wr_en     = 1'b0;
      rf_wr_addr   = '0;
      rf_wr_data   = '0;
      out_ready    = 1'b0;
      clear        = 1'b0;
   endtask

   task automatic drive(input logic cv, input logic [31:0] pc, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
      commit_valid = cv;
      commit_pc    = pc;
      commit_inst  = pc ^ INST_X;
      rf_wr_en     = we;
      rf_wr_addr   = wa;
      rf_wr_data   = wd;
   endtask

   task automatic do_clear();
      idle();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic burst(input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         drive(1'b1, base + 32'(4 * k), 1'b0, '0, '0);
         tick();
      end
      idle();
   endtask

   function automatic logic [127:0] t4(input logic [31:0] a3, input logic [31:0] a2,
                                      input logic [31:0] a1, input logic [31:0] a0);
      return {a3, a2, a1, a0};
   endfunction

   function automatic vec_t mk(input logic cv, input logic [31:0] pc, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd, input logic filt,
                               input logic en, input logic rdy, input logic [4:0] e_cnt,
                               input logic e_val, input logic [31:0] e_pc,
                               input logic [127:0] e_taps, input logic [127:0] e_live);
      vec_t v;
      v.cv = cv; v.pc = pc; v.we = we; v.wa = wa; v.wd = wd; v.filt = filt;
      v.en = en; v.rdy = rdy; v.e_cnt = e_cnt; v.e_val = e_val; v.e_pc = e_pc;
      v.e_taps = e_taps; v.e_live = e_live;
      return v;
   endfunction

   initial begin
      logic [127:0] l0, l1, l3, l8;
      l0 = t4(32'h0, 32'h0, 32'h0, 32'h55);
      l1 = t4(32'h0, 32'h0, 32'h1010, 32'h55);
      l3 = t4(32'h99, 32'h0, 32'h1010, 32'h55);
      l8 = t4(32'h99, 32'hAAAA, 32'h1010, 32'h55);
      vecs[0] = mk(1, 32'h100, 1, 5'd3,  32'h55,   0, 1, 0, 5'd1, 1, 32'h100, l0, l0);
      vecs[1] = mk(0, 32'h0,   1, 5'd10, 32'h1010, 0, 1, 0, 5'd1, 1, 32'h100, l0, l1);
      vecs[2] = mk(1, 32'h104, 1, 5'd5,  32'h77,   1, 1, 0, 5'd1, 1, 32'h100, l0, l1);
      vecs[3] = mk(1, 32'h108, 1, 5'd9,  32'h99,   1, 1, 0, 5'd2, 1, 32'h100, l0, l3);
      vecs[4] = mk(0, 32'h0,   0, 5'd0,  32'h0,    0, 1, 1, 5'd1, 1, 32'h108, l3, l3);
      vecs[5] = mk(1, 32'h10C, 0, 5'd0,  32'h0,    0, 1, 1, 5'd1, 1, 32'h10C, l3, l3);
      vecs[6] = mk(1, 32'h110, 0, 5'd0,  32'h0,    0, 0, 0, 5'd1, 1, 32'h10C, l3, l3);
      vecs[7] = mk(0, 32'h0,   0, 5'd0,  32'h0,    0, 1, 1, 5'd0, 0, 32'h0,   '0, l3);
      vecs[8] = mk(1, 32'h114, 1, 5'd1,  32'hAAAA, 0, 1, 1, 5'd1, 1, 32'h114, l8, l8);
      vecs[9] = mk(0, 32'h0,   0, 5'd0,  32'h0,    0, 1, 1, 5'd0, 0, 32'h0,   '0, l8);

      rst = 1'b0;
      enable = 1'b1;
      mode_filter = 1'b0;
      overwrite = 1'b0;
      tap_sel = {5'd9, 5'd1, 5'd10, 5'd0};
      idle();
      #12;
      chk("reset_valid", 128'(out_valid), 128'(0));
      chk("reset_count", 128'(count), 128'(0));
      chk("reset_drop",  128'(drop_cnt), 128'(0));
      chk("reset_live",  tap_live, 128'(0));
      chk("reset_pc",    128'(out_pc), 128'(0));
      rst = 1'b1;
      tick();

      // x0 tap never updates and never counts as a hit
      mode_filter = 1'b1;
      drive(1'b1, 32'h50, 1'b1, 5'd0, 32'hFF);
      tick();
      idle();
      chk("x0_live",  tap_live, 128'(0));
      chk("x0_count", 128'(count), 128'(0));
      chk("x0_valid", 128'(out_valid), 128'(0));
      mode_filter = 1'b0;
      tap_sel = {5'd9, 5'd1, 5'd10, 5'd3};

      for (int v = 0; v < 10; v++) begin
         drive(vecs[v].cv, vecs[v].pc, vecs[v].we, vecs[v].wa, vecs[v].wd);
         mode_filter = vecs[v].filt;
         enable      = vecs[v].en;
         out_ready   = vecs[v].rdy;
         tick();
         chk($sformatf("v%0d_count", v), 128'(count), 128'(vecs[v].e_cnt));
         chk($sformatf("v%0d_valid", v), 128'(out_valid), 128'(vecs[v].e_val));
         chk($sformatf("v%0d_pc", v), 128'(out_pc), 128'(vecs[v].e_pc));
         chk($sformatf("v%0d_inst", v), 128'(out_inst),
             vecs[v].e_val ? 128'(vecs[v].e_pc ^ INST_X) : 128'(0));
         chk($sformatf("v%0d_taps", v), out_taps, vecs[v].e_taps);
         chk($sformatf("v%0d_live", v), tap_live, vecs[v].e_live);
      end
      idle();
      mode_filter = 1'b0;
      enable = 1'b1;

      // Fill past full with drop policy
      do_clear();
      chk("clr_count", 128'(count), 128'(0));
      overwrite = 1'b0;
      burst(20, 32'h1000);
      chk("drop_count", 128'(count), 128'(16));
      chk("drop_drops", 128'(drop_cnt), 128'(4));
      chk("drop_head",  128'(out_pc), 128'(32'h1000));

      // Full with simultaneous pop and push: no loss
      drive(1'b1, 32'h2000, 1'b0, '0, '0);
      out_ready = 1'b1;
      tick();
      idle();
      chk("fullpp_count", 128'(count), 128'(16));
      chk("fullpp_drops", 128'(drop_cnt), 128'(4));
      chk("fullpp_head",  128'(out_pc), 128'(32'h1004));

      // Fill past full with evict policy, then saturate the drop counter
      do_clear();
      overwrite = 1'b1;
      burst(20, 32'h1000);
      chk("evict_count", 128'(count), 128'(16));
      chk("evict_drops", 128'(drop_cnt), 128'(4));
      chk("evict_head",  128'(out_pc), 128'(32'h1010));
      burst(5, 32'h3000);
      chk("sat_drops", 128'(drop_cnt), 128'(7));
      chk("sat_count", 128'(count), 128'(16));
      chk("sat_head",  128'(out_pc), 128'(32'h1024));
      overwrite = 1'b0;

      // Asynchronous reset mid-drain
      do_clear();
      burst(7, 32'h4000);
      chk("pre_rst_count", 128'(count), 128'(7));
      #2 rst = 1'b0;
      #1;
      chk("arst_count", 128'(count), 128'(0));
      chk("arst_valid", 128'(out_valid), 128'(0));
      chk("arst_pc",    128'(out_pc), 128'(0));
      chk("arst_taps",  out_taps, 128'(0));
      chk("arst_live",  tap_live, 128'(0));
      #1 rst = 1'b1;

      // Clear flushes entries but keeps shadows
      drive(1'b1, 32'h5000, 1'b1, 5'd3, 32'h33);
      tick();
      burst(2, 32'h5004);
      chk("preclr_count", 128'(count), 128'(3));
      chk("preclr_live",  tap_live, t4(32'h0, 32'h0, 32'h0, 32'h33));
      do_clear();
      chk("clr3_count", 128'(count), 128'(0));
      chk("clr3_valid", 128'(out_valid), 128'(0));
      chk("clr3_live",  tap_live, t4(32'h0, 32'h0, 32'h0, 32'h33));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Parametrised successor to the fixed debug taps on the single-cycle processor (register 3, register 10, data-memory word 36 and so on).
- Shadows NUM_TAPS run-time-selectable architectural registers from the writeback port.
- On each retired instruction, captures {pc, instruction, tap values} into a DEPTH-entry FIFO.
- The bench or a debug host drains the FIFO through a valid/ready port.
- Sits beside the processor core and observes only; it never back-pressures the core.

Parameters:
- DATA_W, 32, register/data width.
- PC_W, 32, program-counter width.
- RADDR_W, 5, register-index width (32 registers; x0 hard-wired zero).
- NUM_TAPS, 4, number of shadowed registers.
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- CNT_W, 16, drop-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; shadows update regardless.
- clear  in  1  synchronous flush of FIFO and drop counter.
- mode_filter  in  1  0: record every commit; 1: record only commits that write a tapped register.
- overwrite  in  1  0: drop new entry when full; 1: evict oldest entry.
- tap_sel  in  NUM_TAPS*RADDR_W  register index per tap; slice i feeds tap i.
- commit_valid  in  1  instruction retires this cycle.
- commit_pc  in  PC_W  PC of the retiring instruction.
- commit_inst  in  32  encoding of the retiring instruction.
- rf_wr_en  in  1  register-file write strobe.
- rf_wr_addr  in  RADDR_W  write index.
- rf_wr_data  in  DATA_W  write data.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_pc  out  PC_W  head entry PC.
- out_inst  out  32  head entry instruction.
- out_taps  out  NUM_TAPS*DATA_W  head entry tap values.
- tap_live  out  NUM_TAPS*DATA_W  current shadow values.
- count  out  $clog2(DEPTH)+1  occupancy.
- drop_cnt  out  CNT_W  saturating count of lost entries.

Behaviour:
- Reset (rst=0, asynchronous) forces the following to 0: all shadows, read/write pointers, count, drop_cnt, out_valid, out_pc, out_inst, out_taps and tap_live.
- Shadow update, per tap i: shadow[i] <= rf_wr_data when rf_wr_en && rf_wr_addr==tap_sel[i] && rf_wr_addr!=0.
  - A tap selecting x0 reads 0 permanently.
  - Several taps may select the same register; all of them update.
- Capture condition: enable && commit_valid && (!mode_filter || hit), where hit = rf_wr_en && rf_wr_addr!=0 && rf_wr_addr matches any tap_sel.
- Captured tap values include the same-cycle writeback (bypassed), i.e. the post-commit architectural state.
- Latency: capture at edge N -> entry visible and out_valid=1 in the cycle after edge N.
- Pop: on an edge with out_valid && out_ready. Head outputs are a combinational read of the storage at the read pointer.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - Empty: pointers equal.
  - Full: indices equal, wrap bits differ.
- Push and pop on the same edge:
  - Not full: both occur; count unchanged.
  - Full: both occur; no drop.
  - Empty: the push lands; out_valid=1 next cycle; the pop is ignored because out_valid=0.
- Push when full with no pop:
  - overwrite=0: new entry discarded, drop_cnt+1.
  - overwrite=1: oldest entry evicted (read pointer advances), new entry written, drop_cnt+1.
- drop_cnt saturates at 2^CNT_W-1.
- clear=1: pointers, count and drop_cnt go to 0 at the next edge. Shadows are kept. clear takes priority over a push or pop on the same edge.
- Changing tap_sel mid-run does not alter existing FIFO entries or shadow contents; a shadow tracks its new register from its next write onward.
- Reset asserted mid-drain discards all entries immediately.

Optional Feature:
- Macro: TRACE_MEM_WATCH_EN.
- When defined, adds these ports:
  - mem_wr_en in 1.
  - mem_addr in 32.
  - mem_wr_data in DATA_W.
  - watch_addr in 32.
  - watch_data out DATA_W.
- watch_data is a shadow of the word at watch_addr. It is updated on mem_wr_en && mem_addr==watch_addr, is reset to 0, and is appended to each entry as out_watch (out, DATA_W).
- A store to watch_addr also counts as a hit in filter mode.
- When undefined, none of these ports or this logic exist.

Decomposition:
- Package commit_trace_pkg holds the entry struct trace_entry_t {pc, inst, taps} and a localparam for pointer width.
- One sub-module, trace_fifo: a generic DEPTH x entry FIFO with overwrite/drop logic and counters.
- The top level holds the shadow taps, hit detection and capture qualification.

Test Plan:
- tap_sel={3,10,1,9}; commit writing x3=0x55 with mode_filter=0 -> one entry with out_taps[0]=0x55, others 0, out_valid one cycle later.
- tap_sel[0]=0; write x0=0xFF -> tap_live[0] stays 0; with mode_filter=1 no entry is captured.
- 20 consecutive commits, out_ready=0, overwrite=0 -> count=16, drop_cnt=4, head pc equals the 1st commit's pc.
- Same stimulus with overwrite=1 -> count=16, drop_cnt=4, head pc equals the 5th commit's pc.
- FIFO full, out_ready=1 and commit on the same edge -> count stays 16, drop_cnt unchanged.
- rst pulsed low asynchronously while count=7 -> all outputs 0 immediately; clear=1 with count=3 -> count=0 next edge, tap_live retained.
